// File: rtl/gain_sequencer.sv
// gain_sequencer: streams N samples from an input RAM, scales each one by an
// unsigned fixed-point gain with saturation, and writes the results to an
// output RAM. A 'done' level reports completion of each run.
module gain_sequencer #(
  parameter int C_DATA_WIDTH = 16,
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_GAIN_FRAC  = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [9:0]              num_of_inp,
  input  logic [7:0]              gain,
  output logic                    done,
  output logic                    busy,
  output logic                    rd_en,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  input  logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    wr_en,
  output logic [C_ADDR_WIDTH-1:0] wr_addr,
  output logic [C_DATA_WIDTH-1:0] wr_data
);

  // Product width: signed sample times a 9-bit signed (zero-extended) gain.
  localparam int P_W = C_DATA_WIDTH + 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Clamp a wide signed value into the signed sample range.
  function automatic logic [C_DATA_WIDTH-1:0] f_saturate(input logic signed [P_W-1:0] s);
    logic [C_DATA_WIDTH-1:0] res;
    if (s[P_W-1:C_DATA_WIDTH-1] == {(P_W-C_DATA_WIDTH+1){s[P_W-1]}}) begin
      res = s[C_DATA_WIDTH-1:0];
    end else if (s[P_W-1]) begin
      res = {1'b1, {(C_DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(C_DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  state_t                  r_state;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_rd_en;
  logic [C_ADDR_WIDTH-1:0] r_rd_addr;
  logic [C_ADDR_WIDTH-1:0] r_last;
  logic [7:0]              r_gain;

  logic                    r_s1_valid;
  logic [C_ADDR_WIDTH-1:0] r_s1_addr;
  logic                    r_wr_en;
  logic [C_ADDR_WIDTH-1:0] r_wr_addr;
  logic [C_DATA_WIDTH-1:0] r_wr_data;

  logic signed [P_W-1:0]   w_sample_ext;
  logic signed [P_W-1:0]   w_gain_ext;
  logic signed [P_W-1:0]   w_product;
  logic signed [P_W-1:0]   w_shifted;

  // rd_data is aligned with stage-1 valid; scale it combinationally and let
  // stage 2 register the saturated result straight onto the write port.
  assign w_sample_ext = P_W'(signed'(rd_data));
  assign w_gain_ext   = P_W'(signed'({1'b0, r_gain}));
  assign w_product    = w_sample_ext * w_gain_ext;
  assign w_shifted    = w_product >>> C_GAIN_FRAC;

  // Run control: accepts start, issues one read per cycle, waits for the last write.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= {C_ADDR_WIDTH{1'b0}};
      r_last    <= {C_ADDR_WIDTH{1'b0}};
      r_gain    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rd_en <= 1'b0;
          if (start) begin
            if (num_of_inp != 10'd0) begin
              r_last    <= C_ADDR_WIDTH'(num_of_inp - 10'd1);
              r_gain    <= gain;
              r_done    <= 1'b0;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= {C_ADDR_WIDTH{1'b0}};
              r_state   <= ST_READ;
            end else begin
              // Empty run completes at once without touching the RAMs.
              r_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_rd_addr == r_last) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          // The write port currently shows the final sample: the run ends here.
          if (r_wr_en && (r_wr_addr == r_last)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath pipeline: stage 1 tracks which address rd_data belongs to, stage 2 writes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= {C_ADDR_WIDTH{1'b0}};
      r_wr_en    <= 1'b0;
      r_wr_addr  <= {C_ADDR_WIDTH{1'b0}};
      r_wr_data  <= {C_DATA_WIDTH{1'b0}};
    end else begin
      r_s1_valid <= r_rd_en;
      r_s1_addr  <= r_rd_addr;
      r_wr_en    <= r_s1_valid;
      if (r_s1_valid) begin
        r_wr_addr <= r_s1_addr;
        r_wr_data <= f_saturate(w_shifted);
      end
    end
  end

  assign done    = r_done;
  assign busy    = r_busy;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_gain_sequencer.sv
// Self-checking bench for gain_sequencer: directed runs from the test plan plus
// randomized runs, compared against a plain-arithmetic reference model.
module tb_gain_sequencer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int GF = 4;

  logic          aclk       = 1'b0;
  logic          areset     = 1'b1;
  logic          start      = 1'b0;
  logic [9:0]    num_of_inp = 10'd0;
  logic [7:0]    gain       = 8'd0;
  logic          done;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = 16'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] mem [0:1023];

  int n_checks   = 0;
  int n_pass     = 0;
  int last_done0 = 0;

  gain_sequencer #(
    .C_DATA_WIDTH(DW),
    .C_ADDR_WIDTH(AW),
    .C_GAIN_FRAC (GF)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .num_of_inp(num_of_inp),
    .gain      (gain),
    .done      (done),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 aclk = ~aclk;

  // Input sample RAM: one-cycle read latency.
  always @(posedge aclk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: real product, floor divide by 2^GF, clamp to the 16-bit range.
  function automatic longint model(input logic [DW-1:0] x, input int g);
    int p;
    int s;
    p = int'($signed(x)) * g;
    s = p >>> GF;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return longint'(s) & 64'hFFFF;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  // One run: start in cycle 0, log reads/writes/busy/done per cycle, then compare.
  // inj  : cycle at which a stray start is pulsed (-1 for none)
  // early: stop after cycle n+2 so the next run starts exactly in cycle n+3
  task automatic do_run(input int n, input int g, input int inj, input bit early);
    int rq_a[$];
    int rq_c[$];
    int wq_a[$];
    int wq_c[$];
    longint wq_d[$];
    int done_cyc;
    int busy_cnt;
    int last;
    int exp_done;
    done_cyc = -1;
    busy_cnt = 0;
    last = early ? n + 2 : n + 6;
    @(posedge aclk); #1;
    num_of_inp = 10'(n);
    gain       = 8'(g);
    start      = 1'b1;
    @(negedge aclk);
    last_done0 = int'(done);
    for (int c = 1; c <= last; c++) begin
      @(posedge aclk); #1;
      start = (c == inj);
      if (c == 1) begin
        num_of_inp = 10'($urandom);
        gain       = 8'($urandom);
      end
      @(negedge aclk);
      if (rd_en) begin rq_a.push_back(int'(rd_addr)); rq_c.push_back(c); end
      if (wr_en) begin wq_a.push_back(int'(wr_addr)); wq_c.push_back(c); wq_d.push_back(longint'(wr_data)); end
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
    end
    start = 1'b0;
    exp_done = early ? -1 : ((n == 0) ? 1 : n + 3);
    check("read_count", rq_a.size(), n);
    check("write_count", wq_a.size(), n);
    check("busy_cycles", busy_cnt, (n == 0) ? 0 : n + 2);
    check("done_cycle", done_cyc, exp_done);
    for (int i = 0; i < rq_a.size() && i < n; i++) begin
      check("rd_addr", rq_a[i], i);
      check("rd_cycle", rq_c[i], 1 + i);
    end
    for (int i = 0; i < wq_a.size() && i < n; i++) begin
      check("wr_addr", wq_a[i], i);
      check("wr_cycle", wq_c[i], 3 + i);
      check("wr_data", wq_d[i], model(mem[i], g));
    end
  endtask

  initial begin
    int cnt_done;
    int cnt_en;
    // Reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_outputs_zero("in_reset");
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_outputs_zero("after_reset");

    // Unity gain
    fill_rand();
    mem[0] = 16'h0001; mem[1] = 16'hFFFF; mem[2] = 16'h7FFF; mem[3] = 16'h8000;
    do_run(4, 8'h10, -1, 1'b0);
    check("unity_last_data", wr_data, 16'h8000);

    // Saturation both ways
    mem[0] = 16'h4000; mem[1] = 16'hA000;
    do_run(2, 8'h20, -1, 1'b0);
    check("sat_neg_data", wr_data, 16'h8000);

    // Floor rounding
    mem[0] = 16'hFFFD;
    do_run(1, 8'h08, -1, 1'b0);
    check("floor_data", wr_data, 16'hFFFE);

    // Zero count
    do_run(0, int'($urandom_range(255, 0)), -1, 1'b0);

    // Stray start during an N=8 run
    fill_rand();
    do_run(8, int'($urandom_range(255, 0)), 5, 1'b0);
    check("busy_start_done_held", done, 1);

    // Back-to-back: second start lands in cycle N+3 of the first run
    fill_rand();
    do_run(5, int'($urandom_range(255, 0)), -1, 1'b1);
    do_run(6, int'($urandom_range(255, 0)), -1, 1'b0);
    check("b2b_done_at_accept", last_done0, 1);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      do_run(int'($urandom_range(40, 1)), int'($urandom_range(255, 0)), -1, 1'b0);
    end

    // Maximum count
    fill_rand();
    do_run(1023, 8'h10, -1, 1'b0);
    check("max_last_wr_addr", wr_addr, 10'h3FE);
    check("max_last_rd_addr", rd_addr, 10'h3FE);

    // Reset in the middle of an N=100 run
    fill_rand();
    @(posedge aclk); #1;
    num_of_inp = 10'd100;
    gain       = 8'h10;
    start      = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_wr_en", wr_en, 1);
    @(posedge aclk); #1;
    areset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    cnt_done = 0;
    cnt_en   = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge aclk);
      if (done) cnt_done++;
      if (rd_en || wr_en || busy) cnt_en++;
    end
    check("post_reset_done_cycles", cnt_done, 0);
    check("post_reset_activity", cnt_en, 0);

    fill_rand();
    do_run(3, int'($urandom_range(255, 0)), -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
